// File: rtl/display_scheduler.sv
// Serial digit-link scheduler: round-robin grant between the calc and key
// requesters, load strobe, completion/timeout wait, holdoff and idle refresh.
module display_scheduler #(
    parameter int REFRESH_CYCLES = 2048,
    parameter int LOAD_CYCLES    = 2,
    parameter int HOLDOFF_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        calc_req,
    input  logic [31:0] calc_digits,
    output logic        calc_ack,
    input  logic        key_req,
    input  logic [31:0] key_digits,
    output logic        key_ack,
    input  logic        tran_done,
    output logic        load_data,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        last_src,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, HOLDOFF} state_t;

    localparam int RW = $clog2(REFRESH_CYCLES);
    // One phase counter is shared by LOAD, WAIT_DONE and HOLDOFF.
    localparam int CW = $clog2(LOAD_CYCLES + TIMEOUT_CYCLES + HOLDOFF_CYCLES + 1);

    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_LAST    = CW'(LOAD_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] HOLDOFF_LAST = CW'(HOLDOFF_CYCLES - 1);

    state_t          state;
    logic [RW-1:0]   refresh;
    logic [CW-1:0]   cnt;
    logic            pick_key;

    // Key wins when it is the only requester, or on a tie when calc went last.
    assign pick_key = key_req & (~calc_req | ~last_src);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            refresh     <= '0;
            cnt         <= '0;
            data_out    <= '0;
            load_data   <= 1'b0;
            calc_ack    <= 1'b0;
            key_ack     <= 1'b0;
            busy        <= 1'b0;
            last_src    <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            calc_ack <= 1'b0;
            key_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (calc_req || key_req) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        refresh  <= '0;
                        last_src <= pick_key;
                        data_out <= pick_key ? key_digits : calc_digits;
                        calc_ack <= ~pick_key;
                        key_ack  <= pick_key;
                    end else if (refresh == REFRESH_LAST) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        refresh <= '0;
                    end else begin
                        refresh <= refresh + RW'(1);
                    end
                end
                LOAD: begin
                    // cnt==0 is the grant cycle; the strobe follows for LOAD_CYCLES.
                    if (cnt == LOAD_LAST) begin
                        state     <= WAIT_DONE;
                        load_data <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        load_data <= 1'b1;
                        cnt       <= cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (tran_done) begin
                        timeout_err <= 1'b0;
                        state       <= HOLDOFF;
                        cnt         <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= HOLDOFF;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt == HOLDOFF_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
